hex_packet_tx: RTL and testbench
================================

HEX_PACKET_TX -- requirements
Module: hex_packet_tx

Interface
REQ-001 Parameter: RESOLUTION, default 64, packet width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 intclk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising intclk.
REQ-004 data  input  RESOLUTION  packet word (timestamp/payload/header as assembled upstream), sampled only on an accepted start.
REQ-005 start  input  1  single-cycle capture request.
REQ-006 ready  input  1  byte sink accepts the presented byte this cycle (TXIF-style strobe).
REQ-007 txreg  output  8  ASCII byte presented to the UART/SPI transmitter.
REQ-008 txvalid  output  1  txreg holds a valid byte.
REQ-009 busy  output  1  a packet is being emitted.
REQ-010 dropped  output  1  one-cycle pulse: a start was ignored.

Function
REQ-011 FSM states: IDLE, SEND, CSUM_HI, CSUM_LO, TERM; busy is high in every state except IDLE.
REQ-012 IDLE + start: latch data into a shadow register, load nibble counter = RESOLUTION/4-1, clear checksum, go to SEND; the first character is valid on the next cycle (latency 1).
REQ-013 SEND: txreg = ASCII hex of the shadow nibble at counter index, MSB nibble first; 0-9 -> 0x30-0x39, 10-15 -> 0x41-0x46 (uppercase).
REQ-014 Handshake: a byte is transferred only on a cycle with txvalid & ready; txreg and txvalid hold stable while ready is low; no byte is skipped or repeated.
REQ-015 On each SEND transfer: checksum ^= txreg; counter decrements; a transfer at counter 0 goes to CSUM_HI (macro defined) or TERM (macro undefined).
REQ-016 TERM: txreg = 0x0D; its transfer returns to IDLE with txvalid low the following cycle.
REQ-017 The shadow register is immune to data changes after capture; data is ignored outside accepted starts.
REQ-018 start while busy (including the TERM transfer cycle) is ignored and pulses dropped high for exactly that cycle; the current packet is unaffected.
REQ-019 ready while txvalid is low has no effect.
REQ-020 Back-to-back: a start arriving the cycle after returning to IDLE is accepted; packets never interleave.
REQ-021 Nibble counter width: clog2(RESOLUTION/4)+1 bits; no wrap-around is permitted.

Reset
REQ-022 reset forces IDLE; txvalid=0, busy=0, dropped=0, txreg=0x00, counter=0, checksum=0, shadow=0.
REQ-023 reset mid-packet aborts immediately; no terminator is sent; reset overrides a simultaneous start.

Configuration
REQ-024 Macro HEX_PACKET_CHECKSUM_EN defined: after the last data nibble, CSUM_HI and CSUM_LO emit the 8-bit XOR of all data characters as two uppercase hex chars (high nibble first), then TERM.
REQ-025 Macro undefined: CSUM states are not built; SEND proceeds directly to TERM; the byte sequence is data characters then 0x0D.

Verification
REQ-026 RESOLUTION=8, data=0xA5, start pulse, ready held 1, macro undefined -> txreg 0x41, 0x35, 0x0D on consecutive cycles from start+1; busy low after the third byte.
REQ-027 Same stimulus with HEX_PACKET_CHECKSUM_EN -> 0x41, 0x35, 0x37, 0x34, 0x0D (checksum 0x74).
REQ-028 ready low for 5 cycles after first byte valid -> txreg=0x41 and txvalid=1 held for all 5 cycles; the sequence then resumes unchanged.
REQ-029 start asserted 2 cycles after an accepted start, data changed to 0xFF -> dropped pulses once; output remains 0x41, 0x35, 0x0D.
REQ-030 reset during second character -> next cycle txvalid=0, busy=0; a following start with data=0x00 yields 0x30, 0x30, 0x0D.

Source files
------------

// File: rtl/hex_packet_tx.sv
// hex_packet_tx: serialises a RESOLUTION-bit word as uppercase ASCII hex characters,
// most significant nibble first, followed by a carriage return (0x0D). Each byte is
// presented on o_txreg/o_txvalid and advances only when the sink raises i_ready.
// Optional build macro HEX_PACKET_CHECKSUM_EN: inserts two hex characters holding the
// XOR of all data characters between the last data character and the terminator.
module hex_packet_tx #(
  parameter int unsigned RESOLUTION = 64
) (
  input  logic                  i_intclk,
  input  logic                  i_reset,
  input  logic [RESOLUTION-1:0] i_data,
  input  logic                  i_start,
  input  logic                  i_ready,
  output logic [7:0]            o_txreg,
  output logic                  o_txvalid,
  output logic                  o_busy,
  output logic                  o_dropped
);

  localparam int unsigned NumNib = RESOLUTION / 4;
  localparam int unsigned CntW   = $clog2(NumNib) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NumNib - 1);

`ifdef HEX_PACKET_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSend   = 3'd1,
    StCsumHi = 3'd2,
    StCsumLo = 3'd3,
    StTerm   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSend = 3'd1,
    StTerm = 3'd4
  } state_e;
`endif

  state_e                r_state;
  logic [RESOLUTION-1:0] r_shadow;
  logic [CntW-1:0]       r_cnt;
  logic [7:0]            r_csum;
  logic [7:0]            r_txreg;
  logic                  r_txvalid;
  logic                  r_busy;
  logic                  r_dropped;

  logic                  w_xfer;
  logic [CntW-1:0]       w_next_idx;
  logic [3:0]            w_nib;
  logic [3:0]            w_top_nib;
  logic [7:0]            w_csum_next;

  // Nibble 0..15 to uppercase ASCII hex.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign w_xfer      = r_txvalid & i_ready;
  assign w_next_idx  = r_cnt - CntW'(1);
  assign w_nib       = r_shadow[{w_next_idx, 2'b00} +: 4];
  assign w_top_nib   = i_data[RESOLUTION-1 -: 4];
  assign w_csum_next = r_csum ^ r_txreg;

  // Packet FSM; the next byte is computed on the transfer edge so outputs stay registered.
  always_ff @(posedge i_intclk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_csum    <= '0;
      r_txreg   <= 8'h00;
      r_txvalid <= 1'b0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= i_start && (r_state != StIdle);
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_shadow  <= i_data;
            r_cnt     <= CntLast;
            r_csum    <= '0;
            r_txreg   <= hex_char(w_top_nib);
            r_txvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StSend;
          end
        end
        StSend: begin
          if (w_xfer) begin
            r_csum <= w_csum_next;
            if (r_cnt == '0) begin
`ifdef HEX_PACKET_CHECKSUM_EN
              r_txreg <= hex_char(w_csum_next[7:4]);
              r_state <= StCsumHi;
`else
              r_txreg <= 8'h0D;
              r_state <= StTerm;
`endif
            end else begin
              r_cnt   <= w_next_idx;
              r_txreg <= hex_char(w_nib);
            end
          end
        end
`ifdef HEX_PACKET_CHECKSUM_EN
        StCsumHi: begin
          if (w_xfer) begin
            r_txreg <= hex_char(r_csum[3:0]);
            r_state <= StCsumLo;
          end
        end
        StCsumLo: begin
          if (w_xfer) begin
            r_txreg <= 8'h0D;
            r_state <= StTerm;
          end
        end
`endif
        StTerm: begin
          if (w_xfer) begin
            r_txvalid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: begin
          r_txvalid <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign o_txreg   = r_txreg;
  assign o_txvalid = r_txvalid;
  assign o_busy    = r_busy;
  assign o_dropped = r_dropped;

endmodule

// File: tb/tb_hex_packet_tx.sv
// Bench for hex_packet_tx: directed table on an 8-bit instance, random traffic on a
// 32-bit instance against a queue-based byte-stream model. Honours HEX_PACKET_CHECKSUM_EN.
module tb_hex_packet_tx;

  localparam int unsigned ResA = 8;
  localparam int unsigned ResB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [ResA-1:0] data_a;
  logic            start_a, ready_a;
  logic [7:0]      txreg_a;
  logic            txvalid_a, busy_a, dropped_a;
  logic [ResB-1:0] data_b;
  logic            start_b, ready_b;
  logic [7:0]      txreg_b;
  logic            txvalid_b, busy_b, dropped_b;

  hex_packet_tx #(.RESOLUTION(ResA)) u_dut_a (
    .i_intclk (clk),
    .i_reset  (rst),
    .i_data   (data_a),
    .i_start  (start_a),
    .i_ready  (ready_a),
    .o_txreg  (txreg_a),
    .o_txvalid(txvalid_a),
    .o_busy   (busy_a),
    .o_dropped(dropped_a)
  );

  hex_packet_tx #(.RESOLUTION(ResB)) u_dut_b (
    .i_intclk (clk),
    .i_reset  (rst),
    .i_data   (data_b),
    .i_start  (start_b),
    .i_ready  (ready_b),
    .o_txreg  (txreg_b),
    .o_txvalid(txvalid_b),
    .o_busy   (busy_b),
    .o_dropped(dropped_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] c_hi;
    logic [7:0] c_lo;
    logic [7:0] k_hi;
    logic [7:0] k_lo;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] exp_a[$];
  logic [7:0] q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input vec_t v);
    exp_a = {};
    exp_a.push_back(v.c_hi);
    exp_a.push_back(v.c_lo);
`ifdef HEX_PACKET_CHECKSUM_EN
    exp_a.push_back(v.k_hi);
    exp_a.push_back(v.k_lo);
`endif
    exp_a.push_back(8'h0D);
  endtask

  // Checks exp_a byte by byte with ready high, then the idle state.
  task automatic expect_stream(input string tag);
    for (int i = 0; i < exp_a.size(); i++) begin
      chk($sformatf("%s txvalid[%0d]", tag, i), txvalid_a, 1);
      chk($sformatf("%s txreg[%0d]", tag, i), txreg_a, exp_a[i]);
      chk($sformatf("%s busy[%0d]", tag, i), busy_a, 1);
      tick();
    end
    chk({tag, " idle txvalid"}, txvalid_a, 0);
    chk({tag, " idle busy"}, busy_a, 0);
  endtask

  task automatic run_pkt_a(input vec_t v, input string tag);
    load_exp(v);
    data_a  = v.data;
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    data_a  = 8'($urandom);
    expect_stream(tag);
  endtask

  // Reference byte stream for a 32-bit word: hex chars, optional XOR checksum, CR.
  task automatic build_b(input logic [ResB-1:0] d);
    logic [7:0] cs;
    int         nib;
    cs = 8'h00;
    for (int i = ResB / 4 - 1; i >= 0; i--) begin
      logic [7:0] ch;
      nib = int'((d >> (4 * i)) & 32'hF);
      ch  = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
      cs  = cs ^ ch;
      q_b.push_back(ch);
    end
`ifdef HEX_PACKET_CHECKSUM_EN
    nib = int'(cs) / 16;
    q_b.push_back((nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10));
    nib = int'(cs) % 16;
    q_b.push_back((nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10));
`endif
    q_b.push_back(8'h0D);
  endtask

  initial begin
    int         drops;
    logic       st, rd, exp_drop;
    logic [31:0] d;

    tbl[0] = '{data: 8'hA5, c_hi: 8'h41, c_lo: 8'h35, k_hi: 8'h37, k_lo: 8'h34};
    tbl[1] = '{data: 8'h00, c_hi: 8'h30, c_lo: 8'h30, k_hi: 8'h30, k_lo: 8'h30};
    tbl[2] = '{data: 8'hFF, c_hi: 8'h46, c_lo: 8'h46, k_hi: 8'h30, k_lo: 8'h30};
    tbl[3] = '{data: 8'h9C, c_hi: 8'h39, c_lo: 8'h43, k_hi: 8'h37, k_lo: 8'h41};
    tbl[4] = '{data: 8'h3E, c_hi: 8'h33, c_lo: 8'h45, k_hi: 8'h37, k_lo: 8'h36};

    rst = 1'b1;
    data_a = '0; start_a = 1'b0; ready_a = 1'b0;
    data_b = '0; start_b = 1'b0; ready_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset txvalid", txvalid_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset dropped", dropped_a, 0);
    chk("reset txreg", txreg_a, 8'h00);
    tick();

    // Table, back to back: each start lands the cycle after the previous return to idle.
    for (int i = 0; i < 5; i++) run_pkt_a(tbl[i], $sformatf("tbl%0d", i));

    // Sink stalls with the first byte presented.
    load_exp(tbl[0]);
    data_a = 8'hA5; start_a = 1'b1; ready_a = 1'b0;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall txvalid[%0d]", k), txvalid_a, 1);
      chk($sformatf("stall txreg[%0d]", k), txreg_a, 8'h41);
      tick();
    end
    ready_a = 1'b1;
    expect_stream("stall resume");

    // Starts while busy: two cycles after acceptance and on the terminator transfer.
    load_exp(tbl[0]);
    data_a = 8'hA5; start_a = 1'b1; ready_a = 1'b1;
    tick();
    drops = 0;
    for (int k = 0; k < exp_a.size(); k++) begin
      chk($sformatf("busy-start txreg[%0d]", k), txreg_a, exp_a[k]);
      chk($sformatf("busy-start txvalid[%0d]", k), txvalid_a, 1);
      if (dropped_a) drops++;
      start_a = (k == 1) || (k == exp_a.size() - 1);
      data_a  = 8'hFF;
      tick();
    end
    start_a = 1'b0;
    if (dropped_a) drops++;
    chk("busy-start idle txvalid", txvalid_a, 0);
    tick();
    chk("busy-start dropped clears", dropped_a, 0);
    chk("busy-start drop count", drops, 2);

    // Reset during the second character, with a simultaneous start.
    data_a = 8'hA5; start_a = 1'b1; ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("pre-reset txreg", txreg_a, 8'h35);
    rst = 1'b1; start_a = 1'b1; data_a = 8'h00;
    tick();
    rst = 1'b0; start_a = 1'b0;
    chk("abort txvalid", txvalid_a, 0);
    chk("abort busy", busy_a, 0);
    chk("abort txreg", txreg_a, 8'h00);
    tick();
    chk("abort stays idle", txvalid_a, 0);
    run_pkt_a(tbl[1], "post-reset");

    // Random traffic on the wide instance against the byte-queue model.
    exp_drop = 1'b0;
    q_b = {};
    for (int c = 0; c < 800; c++) begin
      chk("rnd txvalid", txvalid_b, (q_b.size() != 0));
      chk("rnd busy", busy_b, (q_b.size() != 0));
      chk("rnd dropped", dropped_b, exp_drop);
      if (q_b.size() != 0) chk("rnd txreg", txreg_b, q_b[0]);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) < 6);
      d  = $urandom;
      start_b = st; ready_b = rd; data_b = d;
      exp_drop = st && (q_b.size() != 0);
      if (q_b.size() == 0) begin
        if (st) build_b(d);
      end else if (rd) begin
        void'(q_b.pop_front());
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
